// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT transfer scheduler.
package sd_dat_pkg;

    localparam int unsigned TO_W_DEFAULT = 16;
    localparam int unsigned BLK_W        = 11;

    // One-hot scheduler states.
    typedef enum logic [7:0] {
        StIdle     = 8'b0000_0001,
        StFifoWait = 8'b0000_0010,
        StBlkStart = 8'b0000_0100,
        StBlkXfer  = 8'b0000_1000,
        StCardBusy = 8'b0001_0000,
        StStop     = 8'b0010_0000,
        StDone     = 8'b0100_0000,
        StError    = 8'b1000_0000
    } state_e;

    localparam logic [1:0] ErrNone      = 2'b00;
    localparam logic [1:0] ErrCrc       = 2'b01;
    localparam logic [1:0] ErrTimeout   = 2'b10;
    localparam logic [1:0] ErrZeroCount = 2'b11;

    // Where to go once a block has fully completed (read done, or write busy released).
    function automatic state_e after_block(input logic             multi,
                                           input logic [BLK_W-1:0] done_cnt,
                                           input logic [BLK_W-1:0] amount);
        if (done_cnt != amount) begin
            return StFifoWait;
        end else if (multi) begin
            return StStop;
        end else begin
            return StDone;
        end
    endfunction

endpackage

// File: rtl/dat_timeout.sv
// Data-timeout counter: counts enabled cycles since the last clear and flags expiry
// on the cycle whose count would reach the limit.
module dat_timeout
    import sd_dat_pkg::*;
#(
    parameter int unsigned TO_W = TO_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_input,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W:0]   cnt_inc;

    // Cycle counter; saturates so it can never wrap back under the limit.
    always_ff @(posedge clk) begin
        if (reset_input || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
    assign expired = enable && (cnt_inc >= {1'b0, limit});

endmodule

// File: rtl/dat_trans_scheduler.sv
// Sequences SD DAT block transfers: FIFO handshake, per-block start, CRC/busy/timeout
// handling, stop command and completion/error reporting.
module dat_trans_scheduler
    import sd_dat_pkg::*;
#(
    parameter int unsigned TO_W = TO_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_input,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            mode_i,
    input  logic            direction_i,
    input  logic [10:0]     block_amount_i,
    input  logic [TO_W-1:0] timeout_i,
    input  logic            fifo_ready_i,
    input  logic            fifo_full_i,
    input  logic            fifo_empty_i,
    input  logic            block_done_i,
    input  logic            crc_ok_i,
    input  logic            dat0_busy_i,
    input  logic            stop_ack_i,
    output logic            new_trans_o,
    output logic            fifo_enable_o,
    output logic            mode_o,
    output logic            direction_o,
    output logic            stop_req_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [1:0]      err_code_o,
    output logic [10:0]     blocks_done_o
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [BLK_W-1:0] amount_q, amount_d;
    logic [BLK_W-1:0] blocks_q, blocks_d;
    logic [1:0]       err_q, err_d;
    logic             to_enable, to_clear, to_expired;

    assign to_enable = (state_q == StBlkXfer) || (state_q == StCardBusy);
    // Every state change restarts the count.
    assign to_clear  = (state_d != state_q);

    dat_timeout #(
        .TO_W (TO_W)
    ) u_dat_timeout (
        .clk         (clk),
        .reset_input (reset_input),
        .clear       (to_clear),
        .enable      (to_enable),
        .limit       (timeout_i),
        .expired     (to_expired)
    );

    // State and transfer-context registers.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            amount_q <= '0;
            blocks_q <= '0;
            err_q    <= ErrNone;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            amount_q <= amount_d;
            blocks_q <= blocks_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; abort overrides everything decided below it.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        amount_d = amount_q;
        blocks_d = blocks_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    dir_d    = direction_i;
                    amount_d = mode_i ? block_amount_i : 11'd1;
                    blocks_d = '0;
                    err_d    = ErrNone;
                    if (mode_i && (block_amount_i == '0)) begin
                        state_d = StError;
                        err_d   = ErrZeroCount;
                    end else begin
                        state_d = StFifoWait;
                    end
                end
            end
            StFifoWait: begin
                if (fifo_ready_i && !(dir_q && fifo_empty_i) && !(!dir_q && fifo_full_i)) begin
                    state_d = StBlkStart;
                end
            end
            StBlkStart: state_d = StBlkXfer;
            StBlkXfer: begin
                // A completion in the same cycle as expiry counts as a completion.
                if (block_done_i) begin
                    if (crc_ok_i) begin
                        blocks_d = (blocks_q == '1) ? blocks_q : blocks_q + 11'd1;
                        state_d  = dir_q ? StCardBusy : after_block(mode_q, blocks_d, amount_q);
                    end else begin
                        state_d = StError;
                        err_d   = ErrCrc;
                    end
                end else if (to_expired) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end
            end
            StCardBusy: begin
                if (!dat0_busy_i) begin
                    state_d = after_block(mode_q, blocks_q, amount_q);
                end else if (to_expired) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end
            end
            StStop: begin
                if (stop_ack_i) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && abort_i) begin
            state_d  = (mode_q && (blocks_q != '0)) ? StStop : StIdle;
            blocks_d = blocks_q;
            err_d    = err_q;
        end
    end

    assign new_trans_o   = (state_q == StBlkStart);
    assign fifo_enable_o = (state_q == StFifoWait);
    assign stop_req_o    = (state_q == StStop);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign error_o       = (state_q == StError);
    assign mode_o        = mode_q;
    assign direction_o   = dir_q;
    assign err_code_o    = err_q;
    assign blocks_done_o = blocks_q;

endmodule

// File: tb/tb_dat_trans_scheduler.sv
// Directed self-checking bench for dat_trans_scheduler.
module tb_dat_trans_scheduler;

    logic        clk = 1'b0;
    logic        reset_input;
    logic        start_i, abort_i, mode_i, direction_i;
    logic [10:0] block_amount_i;
    logic [15:0] timeout_i;
    logic        fifo_ready_i, fifo_full_i, fifo_empty_i;
    logic        block_done_i, crc_ok_i, dat0_busy_i, stop_ack_i;
    logic        new_trans_o, fifo_enable_o, mode_o, direction_o, stop_req_o;
    logic        busy_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic [10:0] blocks_done_o;

    int errors = 0;
    int checks = 0;
    int nt_pulses = 0;

    dat_trans_scheduler #(
        .TO_W (16)
    ) dut (
        .clk            (clk),
        .reset_input    (reset_input),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .mode_i         (mode_i),
        .direction_i    (direction_i),
        .block_amount_i (block_amount_i),
        .timeout_i      (timeout_i),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_empty_i   (fifo_empty_i),
        .block_done_i   (block_done_i),
        .crc_ok_i       (crc_ok_i),
        .dat0_busy_i    (dat0_busy_i),
        .stop_ack_i     (stop_ack_i),
        .new_trans_o    (new_trans_o),
        .fifo_enable_o  (fifo_enable_o),
        .mode_o         (mode_o),
        .direction_o    (direction_o),
        .stop_req_o     (stop_req_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .err_code_o     (err_code_o),
        .blocks_done_o  (blocks_done_o)
    );

    always #5 clk = ~clk;

    // Pre-edge value of new_trans_o is seen here, so each BLK_START cycle counts once.
    always @(posedge clk) if (new_trans_o === 1'b1) nt_pulses <= nt_pulses + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the next negedge with the transfer in FIFO_WAIT.
    task automatic start_xfer(input logic m, input logic d, input logic [10:0] n);
        mode_i = m; direction_i = d; block_amount_i = n; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Waits (bounded) for the BLK_START pulse; returns at the first BLK_XFER negedge.
    task automatic wait_nt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (new_trans_o === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_input = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done_o, error_o); end
        checks++; if (new_trans_o !== 1'b0 || fifo_enable_o !== 1'b0 || stop_req_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %b%b%b want 000", new_trans_o, fifo_enable_o, stop_req_o); end
        checks++; if (mode_o !== 1'b0 || direction_o !== 1'b0) begin errors++; $display("FAIL reset_cfg: got %b%b want 00", mode_o, direction_o); end
        checks++; if (err_code_o !== 2'b00 || blocks_done_o !== 11'd0) begin errors++; $display("FAIL reset_cnt: got err=%b blk=%0d want 00/0", err_code_o, blocks_done_o); end
        reset_input = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int base;
        base = nt_pulses;
        fifo_ready_i = 1'b1;
        start_xfer(1'b0, 1'b0, 11'd5);
        checks++; if (fifo_enable_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL sr_fifo_wait: got en=%b busy=%b want 1/1", fifo_enable_o, busy_o); end
        @(negedge clk);
        checks++; if (new_trans_o !== 1'b1) begin errors++; $display("FAIL sr_new_trans: got %b want 1", new_trans_o); end
        @(negedge clk);
        checks++; if (new_trans_o !== 1'b0) begin errors++; $display("FAIL sr_new_trans_one_cycle: got %b want 0", new_trans_o); end
        block_done_i = 1'b1; crc_ok_i = 1'b1;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0;
        checks++; if (done_o !== 1'b1 || blocks_done_o !== 11'd1) begin errors++; $display("FAIL sr_done: got done=%b blk=%0d want 1/1", done_o, blocks_done_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL sr_idle: got done=%b busy=%b want 0/0", done_o, busy_o); end
        checks++; if (nt_pulses - base !== 1) begin errors++; $display("FAIL sr_pulses: got %0d want 1", nt_pulses - base); end
    endtask

    task automatic test_multi_write();
        int base;
        bit ok;
        base = nt_pulses;
        fifo_ready_i = 1'b1; fifo_empty_i = 1'b0;
        start_xfer(1'b1, 1'b1, 11'd3);
        for (int b = 0; b < 3; b++) begin
            wait_nt(ok);
            checks++; if (!ok) begin errors++; $display("FAIL mw_wait_block%0d: got no new_trans want pulse", b); end
            block_done_i = 1'b1; crc_ok_i = 1'b1; dat0_busy_i = 1'b1;
            @(negedge clk);
            block_done_i = 1'b0; crc_ok_i = 1'b0;
            repeat (5) @(negedge clk);
            checks++; if (busy_o !== 1'b1 || blocks_done_o !== 11'(b + 1)) begin errors++; $display("FAIL mw_card_busy%0d: got busy=%b blk=%0d want 1/%0d", b, busy_o, blocks_done_o, b + 1); end
            dat0_busy_i = 1'b0;
            @(negedge clk);
        end
        checks++; if (stop_req_o !== 1'b1 || mode_o !== 1'b1 || direction_o !== 1'b1) begin errors++; $display("FAIL mw_stop: got stop=%b mode=%b dir=%b want 111", stop_req_o, mode_o, direction_o); end
        repeat (3) @(negedge clk);
        checks++; if (stop_req_o !== 1'b1) begin errors++; $display("FAIL mw_stop_hold: got %b want 1", stop_req_o); end
        stop_ack_i = 1'b1;
        @(negedge clk);
        stop_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || stop_req_o !== 1'b0 || blocks_done_o !== 11'd3) begin errors++; $display("FAIL mw_done: got done=%b stop=%b blk=%0d want 1/0/3", done_o, stop_req_o, blocks_done_o); end
        @(negedge clk);
        checks++; if (nt_pulses - base !== 3) begin errors++; $display("FAIL mw_pulses: got %0d want 3", nt_pulses - base); end
    endtask

    task automatic test_crc_error();
        bit ok;
        start_xfer(1'b1, 1'b0, 11'd4);
        wait_nt(ok);
        block_done_i = 1'b1; crc_ok_i = 1'b1;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0;
        wait_nt(ok);
        checks++; if (!ok) begin errors++; $display("FAIL crc_wait_block2: got no new_trans want pulse"); end
        block_done_i = 1'b1; crc_ok_i = 1'b0;
        @(negedge clk);
        block_done_i = 1'b0;
        checks++; if (error_o !== 1'b1 || err_code_o !== 2'b01 || blocks_done_o !== 11'd1) begin errors++; $display("FAIL crc_error: got err=%b code=%b blk=%0d want 1/01/1", error_o, err_code_o, blocks_done_o); end
        @(negedge clk);
        checks++; if (error_o !== 1'b0 || busy_o !== 1'b0 || err_code_o !== 2'b01) begin errors++; $display("FAIL crc_hold: got err=%b busy=%b code=%b want 0/0/01", error_o, busy_o, err_code_o); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        timeout_i = 16'd20;
        start_xfer(1'b0, 1'b0, 11'd1);
        wait_nt(ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (error_o !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_early: got early error want none"); end
        checks++; if (error_o !== 1'b1 || err_code_o !== 2'b10) begin errors++; $display("FAIL to_expire: got err=%b code=%b want 1/10", error_o, err_code_o); end
        @(negedge clk);
        timeout_i = 16'd1000;
    endtask

    task automatic test_done_wins();
        bit ok;
        timeout_i = 16'd3;
        start_xfer(1'b0, 1'b0, 11'd1);
        checks++; if (err_code_o !== 2'b00) begin errors++; $display("FAIL dw_err_clear: got %b want 00", err_code_o); end
        wait_nt(ok);
        repeat (2) @(negedge clk);
        block_done_i = 1'b1; crc_ok_i = 1'b1;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0;
        checks++; if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL dw_done: got done=%b err=%b want 1/0", done_o, error_o); end
        @(negedge clk);
        timeout_i = 16'd1000;
    endtask

    task automatic test_abort();
        int base;
        bit ok;
        base = nt_pulses;
        start_xfer(1'b1, 1'b0, 11'd4);
        wait_nt(ok);
        block_done_i = 1'b1; crc_ok_i = 1'b1;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++; if (stop_req_o !== 1'b1 || blocks_done_o !== 11'd1) begin errors++; $display("FAIL ab_stop: got stop=%b blk=%0d want 1/1", stop_req_o, blocks_done_o); end
        repeat (2) @(negedge clk);
        checks++; if (stop_req_o !== 1'b1) begin errors++; $display("FAIL ab_stop_hold: got %b want 1", stop_req_o); end
        stop_ack_i = 1'b1;
        @(negedge clk);
        stop_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ab_done: got %b want 1", done_o); end
        @(negedge clk);
        checks++; if (nt_pulses - base !== 1 || busy_o !== 1'b0) begin errors++; $display("FAIL ab_end: got pulses=%0d busy=%b want 1/0", nt_pulses - base, busy_o); end
        // Abort before any block completes returns straight to idle.
        fifo_ready_i = 1'b0;
        start_xfer(1'b1, 1'b0, 11'd4);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || stop_req_o !== 1'b0) begin errors++; $display("FAIL ab_idle: got busy=%b stop=%b want 0/0", busy_o, stop_req_o); end
        fifo_ready_i = 1'b1;
    endtask

    task automatic test_fifo_gate();
        int base;
        bit ok;
        base = nt_pulses;
        fifo_empty_i = 1'b1;
        start_xfer(1'b0, 1'b1, 11'd1);
        repeat (3) @(negedge clk);
        checks++; if (fifo_enable_o !== 1'b1 || new_trans_o !== 1'b0 || nt_pulses - base !== 0) begin errors++; $display("FAIL fg_hold: got en=%b nt=%b pulses=%0d want 1/0/0", fifo_enable_o, new_trans_o, nt_pulses - base); end
        fifo_empty_i = 1'b0;
        wait_nt(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fg_release: got no new_trans want pulse"); end
        block_done_i = 1'b1; crc_ok_i = 1'b1; dat0_busy_i = 1'b0;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL fg_card_busy: got busy=%b done=%b want 1/0", busy_o, done_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL fg_done: got %b want 1", done_o); end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        int base;
        base = nt_pulses;
        start_xfer(1'b1, 1'b0, 11'd0);
        checks++; if (error_o !== 1'b1 || err_code_o !== 2'b11) begin errors++; $display("FAIL zc_error: got err=%b code=%b want 1/11", error_o, err_code_o); end
        @(negedge clk);
        checks++; if (error_o !== 1'b0 || err_code_o !== 2'b11 || nt_pulses - base !== 0) begin errors++; $display("FAIL zc_hold: got err=%b code=%b pulses=%0d want 0/11/0", error_o, err_code_o, nt_pulses - base); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_xfer(1'b1, 1'b0, 11'd3);
        wait_nt(ok);
        block_done_i = 1'b1; crc_ok_i = 1'b1;
        @(negedge clk);
        block_done_i = 1'b0; crc_ok_i = 1'b0;
        wait_nt(ok);
        checks++; if (mode_o !== 1'b1 || blocks_done_o !== 11'd1 || busy_o !== 1'b1) begin errors++; $display("FAIL rm_pre: got mode=%b blk=%0d busy=%b want 1/1/1", mode_o, blocks_done_o, busy_o); end
        reset_input = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || mode_o !== 1'b0 || direction_o !== 1'b0 || blocks_done_o !== 11'd0) begin errors++; $display("FAIL rm_state: got busy=%b mode=%b dir=%b blk=%0d want 0/0/0/0", busy_o, mode_o, direction_o, blocks_done_o); end
        checks++; if (new_trans_o !== 1'b0 || fifo_enable_o !== 1'b0 || stop_req_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0 || err_code_o !== 2'b00) begin errors++; $display("FAIL rm_outputs: got nt=%b en=%b stop=%b done=%b err=%b code=%b want all 0", new_trans_o, fifo_enable_o, stop_req_o, done_o, error_o, err_code_o); end
        reset_input = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_input = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; direction_i = 1'b0;
        block_amount_i = '0; timeout_i = 16'd1000; fifo_ready_i = 1'b0; fifo_full_i = 1'b0;
        fifo_empty_i = 1'b0; block_done_i = 1'b0; crc_ok_i = 1'b0; dat0_busy_i = 1'b0;
        stop_ack_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_multi_write();
        test_crc_error();
        test_timeout();
        test_done_wins();
        test_abort();
        test_fifo_gate();
        test_zero_count();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
